// File: rtl/extract_pkg.sv
// ============================================================================
// Module      : extract_pkg
// Description : Packet field layout and saturating-counter helper for extract_router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package extract_pkg;

    localparam int DEF_PACKET_BITS   = 97;
    localparam int DEF_NUM_LEAF_BITS = 6;
    localparam int DEF_NUM_PORT_BITS = 4;

    // Field offsets for the default packet layout: valid | leaf | port | payload.
    localparam int VLD_BIT = DEF_PACKET_BITS - 1;
    localparam int LEAF_HI = VLD_BIT - 1;
    localparam int LEAF_LO = LEAF_HI - DEF_NUM_LEAF_BITS + 1;
    localparam int PORT_HI = LEAF_LO - 1;
    localparam int PORT_LO = PORT_HI - DEF_NUM_PORT_BITS + 1;

    // Saturating increment of a counter that is w bits wide (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/extract_router_if.sv
// ============================================================================
// Module      : extract_router_if
// Description : Packet and channel handshake bundle between BFT, router and consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface extract_router_if #(
    parameter int PACKET_BITS = extract_pkg::DEF_PACKET_BITS
);
    logic [PACKET_BITS-1:0] din_leaf_bft2interface;
    logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
    logic                   resend;
    logic [PACKET_BITS-1:0] stream_in;
    logic                   stream_in_ready;
    logic [PACKET_BITS-1:0] stream_out;
    logic                   stream_valid;
    logic                   stream_ready;
    logic [PACKET_BITS-1:0] configure_out;
    logic                   cfg_valid;
    logic                   cfg_ready;

    // Router side
    modport slave (
        input  din_leaf_bft2interface, resend, stream_in, stream_ready, cfg_ready,
        output dout_leaf_interface2bft, stream_in_ready, stream_out, stream_valid,
               configure_out, cfg_valid
    );

    // BFT / consumer side
    modport master (
        output din_leaf_bft2interface, resend, stream_in, stream_ready, cfg_ready,
        input  dout_leaf_interface2bft, stream_in_ready, stream_out, stream_valid,
               configure_out, cfg_valid
    );
endinterface

`default_nettype wire

// File: rtl/extract_router_pkt_fifo.sv
// ============================================================================
// Module      : pkt_fifo
// Description : First-word-fall-through packet FIFO; head is zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  full,
    input  wire logic             pop,
    output logic                  valid,
    output logic      [WIDTH-1:0] dout
);
    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_PTR_ONE = (c_AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign valid     = !w_empty;
    assign dout      = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/extract_router.sv
// ============================================================================
// Module      : extract_router
// Description : Steers BFT leaf packets into config/stream FIFOs and holds the
//               outbound stream packet for BFT resend. Option: LEAF_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module extract_router
    import extract_pkg::*;
#(
    parameter int PACKET_BITS     = DEF_PACKET_BITS,
    parameter int NUM_LEAF_BITS   = DEF_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS   = DEF_NUM_PORT_BITS,
    parameter int CFG_PORT_MAX    = 1,
    parameter int STREAM_PORT_MAX = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_BITS        = 16
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    extract_router_if.slave               bus,
    output logic      [CNT_BITS-1:0]      stream_drop_cnt,
    output logic      [CNT_BITS-1:0]      cfg_drop_cnt,
    input  wire logic [NUM_LEAF_BITS-1:0] self_leaf
`ifdef LEAF_CHECK_EN
   ,output logic      [CNT_BITS-1:0]      misroute_cnt
`endif
);
    localparam int c_VLD_BIT = PACKET_BITS - 1;
    localparam int c_PORT_HI = c_VLD_BIT - NUM_LEAF_BITS - 1;
    localparam int c_PORT_LO = c_PORT_HI - NUM_PORT_BITS + 1;
    localparam logic [NUM_PORT_BITS-1:0] c_CFG_MAX    = NUM_PORT_BITS'(CFG_PORT_MAX);
    localparam logic [NUM_PORT_BITS-1:0] c_STREAM_MAX = NUM_PORT_BITS'(STREAM_PORT_MAX);

    logic                     w_vld;
    logic [NUM_PORT_BITS-1:0] w_port;
    logic                     w_leaf_ok;
    logic                     w_cls_cfg;
    logic                     w_cls_stream;
    logic                     w_cfg_full;
    logic                     w_stream_full;
    logic                     w_cfg_pop;
    logic                     w_stream_pop;
    logic                     w_cfg_drop;
    logic                     w_stream_drop;
    logic                     w_hold_vld;
    logic [PACKET_BITS-1:0]   r_hold_pkt;
    logic [CNT_BITS-1:0]      r_cfg_drop;
    logic [CNT_BITS-1:0]      r_stream_drop;

    assign w_vld  = bus.din_leaf_bft2interface[c_VLD_BIT];
    assign w_port = bus.din_leaf_bft2interface[c_PORT_HI:c_PORT_LO];

`ifdef LEAF_CHECK_EN
    localparam int c_LEAF_HI = c_VLD_BIT - 1;
    localparam int c_LEAF_LO = c_LEAF_HI - NUM_LEAF_BITS + 1;

    logic                w_misroute;
    logic [CNT_BITS-1:0] r_misroute;

    assign w_leaf_ok    = (bus.din_leaf_bft2interface[c_LEAF_HI:c_LEAF_LO] == self_leaf);
    assign w_misroute   = w_vld && !w_leaf_ok;
    assign misroute_cnt = r_misroute;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_misroute <= '0;
        else if (w_misroute) r_misroute <= CNT_BITS'(sat_inc(32'(r_misroute), CNT_BITS));
    end
`else
    logic w_unused_self_leaf;
    assign w_leaf_ok          = 1'b1;
    assign w_unused_self_leaf = ^self_leaf;
`endif

    // Ports above the stream range fall back to config.
    assign w_cls_cfg    = w_vld && w_leaf_ok && ((w_port <= c_CFG_MAX) || (w_port > c_STREAM_MAX));
    assign w_cls_stream = w_vld && w_leaf_ok && (w_port > c_CFG_MAX) && (w_port <= c_STREAM_MAX);

    assign w_cfg_pop     = bus.cfg_valid && bus.cfg_ready;
    assign w_stream_pop  = bus.stream_valid && bus.stream_ready;
    assign w_cfg_drop    = w_cls_cfg && w_cfg_full && !w_cfg_pop;
    assign w_stream_drop = w_cls_stream && w_stream_full && !w_stream_pop;

    pkt_fifo #(.WIDTH(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_cls_cfg),
        .push_data (bus.din_leaf_bft2interface),
        .full      (w_cfg_full),
        .pop       (w_cfg_pop),
        .valid     (bus.cfg_valid),
        .dout      (bus.configure_out)
    );

    pkt_fifo #(.WIDTH(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_stream_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_cls_stream),
        .push_data (bus.din_leaf_bft2interface),
        .full      (w_stream_full),
        .pop       (w_stream_pop),
        .valid     (bus.stream_valid),
        .dout      (bus.stream_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_drop    <= '0;
            r_stream_drop <= '0;
        end else begin
            if (w_cfg_drop)    r_cfg_drop    <= CNT_BITS'(sat_inc(32'(r_cfg_drop), CNT_BITS));
            if (w_stream_drop) r_stream_drop <= CNT_BITS'(sat_inc(32'(r_stream_drop), CNT_BITS));
        end
    end

    assign cfg_drop_cnt    = r_cfg_drop;
    assign stream_drop_cnt = r_stream_drop;

    // Outbound holding register: retained only while it is valid and rejected.
    assign w_hold_vld                  = r_hold_pkt[c_VLD_BIT];
    assign bus.dout_leaf_interface2bft = r_hold_pkt;
    assign bus.stream_in_ready         = !w_hold_vld || !bus.resend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_pkt <= '0;
        end else if (!(w_hold_vld && bus.resend)) begin
            r_hold_pkt <= bus.stream_in[c_VLD_BIT] ? bus.stream_in : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_extract_router.sv
// ============================================================================
// Module      : tb_extract_router
// Description : Directed table-driven bench for extract_router (LEAF_CHECK_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_extract_router;
    import extract_pkg::*;

    localparam int PB  = 97;
    localparam int LB  = 6;
    localparam int PTB = 4;
    localparam int CB  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [LB-1:0] self_leaf;
    logic [CB-1:0] stream_drop_cnt;
    logic [CB-1:0] cfg_drop_cnt;
`ifdef LEAF_CHECK_EN
    logic [CB-1:0] misroute_cnt;
`endif

    extract_router_if #(.PACKET_BITS(PB)) bus ();

    extract_router #(
        .PACKET_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB),
        .CFG_PORT_MAX(1), .STREAM_PORT_MAX(8), .FIFO_DEPTH(4), .CNT_BITS(CB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .stream_drop_cnt (stream_drop_cnt),
        .cfg_drop_cnt    (cfg_drop_cnt),
        .self_leaf       (self_leaf)
`ifdef LEAF_CHECK_EN
       ,.misroute_cnt    (misroute_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk(input logic [LB-1:0] leaf, input logic [PTB-1:0] port,
                                         input logic [31:0] tag);
        logic [PB-1:0] p;
        p                  = '0;
        p[VLD_BIT]         = 1'b1;
        p[LEAF_HI:LEAF_LO] = leaf;
        p[PORT_HI:PORT_LO] = port;
        p[31:0]            = tag;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, "_stream_valid"}, bus.stream_valid, 1'b0);
        chk_bit({tag, "_cfg_valid"}, bus.cfg_valid, 1'b0);
        chk_pkt({tag, "_stream_out"}, bus.stream_out, '0);
        chk_pkt({tag, "_configure_out"}, bus.configure_out, '0);
        chk_pkt({tag, "_dout"}, bus.dout_leaf_interface2bft, '0);
        chk_cnt({tag, "_stream_drop"}, stream_drop_cnt, '0);
        chk_cnt({tag, "_cfg_drop"}, cfg_drop_cnt, '0);
        chk_bit({tag, "_stream_in_ready"}, bus.stream_in_ready, 1'b1);
    endtask

    typedef struct {
        logic [PTB-1:0] port;
        logic           to_cfg;
    } route_vec_t;

    route_vec_t    vecs[8];
    logic [PB-1:0] exp_pkt;
    logic [PB-1:0] pa;
    logic [PB-1:0] pb;
    logic [PB-1:0] pc;
    logic [31:0]   drain_tags[4];

    initial begin
        vecs[0] = '{4'd0,  1'b1};
        vecs[1] = '{4'd1,  1'b1};
        vecs[2] = '{4'd2,  1'b0};
        vecs[3] = '{4'd8,  1'b0};
        vecs[4] = '{4'd9,  1'b1};
        vecs[5] = '{4'd15, 1'b1};
        vecs[6] = '{4'd5,  1'b0};
        vecs[7] = '{4'd3,  1'b0};
        drain_tags = '{32'd201, 32'd202, 32'd203, 32'd206};

        bus.din_leaf_bft2interface = '0;
        bus.stream_in              = '0;
        bus.resend                 = 1'b0;
        bus.stream_ready           = 1'b1;
        bus.cfg_ready              = 1'b1;
        self_leaf                  = 6'd5;
        reset_n                    = 1'b0;

        #12;
        chk_all_zero("reset");
`ifdef LEAF_CHECK_EN
        chk_cnt("reset_misroute", misroute_cnt, '0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Port routing, consumers always ready
        for (int i = 0; i < 8; i++) begin
            exp_pkt = mk(6'd5, vecs[i].port, 32'(100 + i));
            bus.din_leaf_bft2interface = exp_pkt;
            tick();
            if (vecs[i].to_cfg) begin
                chk_bit($sformatf("route%0d_cfg_valid", i), bus.cfg_valid, 1'b1);
                chk_pkt($sformatf("route%0d_cfg_out", i), bus.configure_out, exp_pkt);
                chk_bit($sformatf("route%0d_stream_valid", i), bus.stream_valid, 1'b0);
            end else begin
                chk_bit($sformatf("route%0d_stream_valid", i), bus.stream_valid, 1'b1);
                chk_pkt($sformatf("route%0d_stream_out", i), bus.stream_out, exp_pkt);
                chk_bit($sformatf("route%0d_cfg_valid", i), bus.cfg_valid, 1'b0);
            end
        end
        bus.din_leaf_bft2interface = '0;
        tick();
        chk_bit("route_end_stream_valid", bus.stream_valid, 1'b0);
        chk_bit("route_end_cfg_valid", bus.cfg_valid, 1'b0);
        chk_cnt("route_stream_drop", stream_drop_cnt, '0);
        chk_cnt("route_cfg_drop", cfg_drop_cnt, '0);

        // Stream overflow: six pushes into a 4-deep FIFO with no consumer
        bus.stream_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.din_leaf_bft2interface = mk(6'd5, 4'd3, 32'(200 + i));
            tick();
        end
        bus.din_leaf_bft2interface = '0;
        chk_bit("ovf_stream_valid", bus.stream_valid, 1'b1);
        chk_pkt("ovf_head", bus.stream_out, mk(6'd5, 4'd3, 32'd200));
        chk_cnt("ovf_stream_drop", stream_drop_cnt, 16'd2);
        chk_cnt("ovf_cfg_drop", cfg_drop_cnt, 16'd0);

        // Full FIFO with simultaneous pop and push: accepted, no drop
        bus.stream_ready = 1'b1;
        bus.din_leaf_bft2interface = mk(6'd5, 4'd3, 32'd206);
        tick();
        bus.din_leaf_bft2interface = '0;
        chk_cnt("fullpop_stream_drop", stream_drop_cnt, 16'd2);
        for (int k = 0; k < 4; k++) begin
            chk_bit($sformatf("drain%0d_valid", k), bus.stream_valid, 1'b1);
            chk_pkt($sformatf("drain%0d_out", k), bus.stream_out, mk(6'd5, 4'd3, drain_tags[k]));
            tick();
        end
        chk_bit("drain_empty_valid", bus.stream_valid, 1'b0);
        chk_pkt("drain_empty_out", bus.stream_out, '0);
        tick();
        chk_cnt("empty_ready_drop", stream_drop_cnt, 16'd2);
        chk_bit("empty_ready_valid", bus.stream_valid, 1'b0);

        // Outbound resend held for three cycles
        pa = mk(6'd1, 4'd2, 32'hA);
        pb = mk(6'd1, 4'd2, 32'hB);
        pc = mk(6'd1, 4'd2, 32'hC);
        bus.stream_in = pa;
        bus.resend    = 1'b0;
        tick();
        chk_pkt("resend_load_a", bus.dout_leaf_interface2bft, pa);
        bus.stream_in = pb;
        bus.resend    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_bit($sformatf("resend%0d_in_ready", k), bus.stream_in_ready, 1'b0);
            tick();
            chk_pkt($sformatf("resend%0d_dout", k), bus.dout_leaf_interface2bft, pa);
        end
        bus.resend = 1'b0;
        #1;
        chk_bit("resend_release_ready", bus.stream_in_ready, 1'b1);
        tick();
        chk_pkt("resend_load_b", bus.dout_leaf_interface2bft, pb);
        bus.stream_in = '0;
        tick();
        chk_pkt("resend_idle_dout", bus.dout_leaf_interface2bft, '0);
        bus.resend    = 1'b1;
        bus.stream_in = pc;
        #1;
        chk_bit("resend_no_hold_ready", bus.stream_in_ready, 1'b1);
        tick();
        chk_pkt("resend_no_hold_load_c", bus.dout_leaf_interface2bft, pc);
        bus.resend = 1'b0;

        // Asynchronous reset with both FIFOs and the holding register occupied
        bus.stream_ready = 1'b0;
        bus.cfg_ready    = 1'b0;
        bus.stream_in    = pa;
        bus.din_leaf_bft2interface = mk(6'd5, 4'd4, 32'd400);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.din_leaf_bft2interface = mk(6'd5, 4'd0, 32'(401 + i));
            tick();
        end
        bus.din_leaf_bft2interface = '0;
        chk_cnt("pre_rst_cfg_drop", cfg_drop_cnt, 16'd1);
        chk_bit("pre_rst_stream_valid", bus.stream_valid, 1'b1);
        chk_pkt("pre_rst_dout", bus.dout_leaf_interface2bft, pa);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.stream_in    = '0;
        bus.stream_ready = 1'b1;
        bus.cfg_ready    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_bit("post_rst_stream_valid", bus.stream_valid, 1'b0);
        chk_bit("post_rst_cfg_valid", bus.cfg_valid, 1'b0);
        chk_pkt("post_rst_dout", bus.dout_leaf_interface2bft, '0);

`ifdef LEAF_CHECK_EN
        // Leaf filtering: only packets addressed to self_leaf are routed
        bus.din_leaf_bft2interface = mk(6'd5, 4'd0, 32'd500);
        tick();
        chk_pkt("leaf_match_cfg_out", bus.configure_out, mk(6'd5, 4'd0, 32'd500));
        bus.din_leaf_bft2interface = mk(6'd7, 4'd0, 32'd501);
        tick();
        bus.din_leaf_bft2interface = '0;
        chk_bit("leaf_miss_cfg_valid", bus.cfg_valid, 1'b0);
        chk_bit("leaf_miss_stream_valid", bus.stream_valid, 1'b0);
        chk_cnt("leaf_misroute_cnt", misroute_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
